data_mem_bytelane: RTL and testbench

Parametrised, byte-addressable data memory for the RISC-V core, replacing the word-only data memory. It supports RV32I load/store sizes (LB/LH/LW/LBU/LHU/SB/SH/SW) through byte lanes and runs a valid/ready request handshake with a registered response. It flags misaligned, out-of-range and illegal-funct3 accesses. A reset-triggered clear sequencer zeroes every word before the block accepts requests.

---
 rtl/data_mem_bytelane_if.sv | 45 ++++
 rtl/data_mem_bytelane.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_bytelane.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus of the byte-lane data memory.
// Master drives requests; slave returns a registered response.
interface data_mem_bytelane_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  chip_select;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  init_busy;

  modport master (
    output chip_select,
    output req_valid,
    output req_write,
    output req_addr,
    output req_funct3,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_error,
    input  init_busy
  );

  modport slave (
    input  chip_select,
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_funct3,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_error,
    output init_busy
  );
endinterface

// File: rtl/data_mem_bytelane.sv
// Byte-addressable RV32I data memory with byte-lane stores,
// extended loads, fault flagging and a clear-on-reset sweep.
module data_mem_bytelane #(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_WIDTH  = 32,
  parameter int CLR_IDX_W   = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_bytelane_if.slave bus
);

  typedef enum logic [0:0] {
    S_CLEAR,
    S_IDLE
  } state_e;

  localparam logic [CLR_IDX_W-1:0] LAST_IDX =
    CLR_IDX_W'(DEPTH_WORDS - 1);

  state_e               state_q;
  state_e               state_d;
  logic [CLR_IDX_W-1:0] idx_q;
  logic [CLR_IDX_W-1:0] idx_d;
  logic                 clr_we;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic                  rsp_valid_q;
  logic                  rsp_valid_d;
  logic [31:0]           rsp_rdata_q;
  logic [31:0]           rsp_rdata_d;
  logic                  rsp_error_q;
  logic                  rsp_error_d;

  logic [1:0]            lane;
  logic [CLR_IDX_W-1:0]  widx;
  logic [ADDR_WIDTH-1:0] hi_bits;
  logic [2:0]            f3;
  logic                  is_h;
  logic                  is_w;
  logic                  f3_ok;
  logic                  oor;
  logic                  misal;
  logic                  fault;
  logic                  accept;
  logic                  st_en;

  logic [3:0]            st_be;
  logic [31:0]           st_data;

  logic                  wr_en;
  logic [CLR_IDX_W-1:0]  wr_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;

  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_data;

  // Sweep / idle controller
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.init_busy = (state_q == S_CLEAR);

  // Request decode
  assign lane    = bus.req_addr[1:0];
  assign widx    = bus.req_addr[CLR_IDX_W+1:2];
  assign hi_bits = bus.req_addr >> (CLR_IDX_W + 2);
  assign oor     = |hi_bits;
  assign f3      = bus.req_funct3;
  assign is_h    = (f3[1:0] == 2'b01);
  assign is_w    = (f3[1:0] == 2'b10);

  always_comb begin
    f3_ok = 1'b0;
    if (bus.req_write) begin
      f3_ok = (f3 == 3'b000) | (f3 == 3'b001)
            | (f3 == 3'b010);
    end else begin
      f3_ok = (f3 == 3'b000) | (f3 == 3'b001)
            | (f3 == 3'b010) | (f3 == 3'b100)
            | (f3 == 3'b101);
    end
  end

  assign misal  = (is_h & lane[0]) | (is_w & (|lane));
  assign fault  = oor | misal | ~f3_ok;
  assign accept = bus.req_valid & bus.req_ready
                & bus.chip_select & ~reset;
  assign st_en  = accept & bus.req_write & ~fault;

  // Store lane steering
  always_comb begin
    st_be   = 4'b0001 << lane;
    st_data = {4{bus.req_wdata[7:0]}};
    unique case (1'b1)
      is_w: begin
        st_be   = 4'b1111;
        st_data = bus.req_wdata;
      end
      is_h: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.req_wdata[7:0]}};
      end
    endcase
  end

  // Single write port shared by the sweep and stores
  always_comb begin
    wr_en   = ~reset & (clr_we | st_en);
    wr_idx  = widx;
    wr_be   = st_be;
    wr_data = st_data;
    if (clr_we) begin
      wr_idx  = idx_q;
      wr_be   = 4'b1111;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Load extraction
  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = lane[1] ? rd_word[31:16]
                           : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    unique case (1'b1)
      is_w: begin
        ld_data = rd_word;
      end
      is_h: begin
        ld_data = {{16{~f3[2] & rd_half[15]}}, rd_half};
      end
      default: begin
        ld_data = {{24{~f3[2] & rd_byte[7]}}, rd_byte};
      end
    endcase
  end

  // Registered response; data/error hold between pulses
  always_comb begin
    rsp_valid_d = accept;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (accept) begin
      rsp_error_d = fault;
      rsp_rdata_d = (fault | bus.req_write) ? '0 : ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane: sweep, lanes,
// faults, mid-sweep reset and back-to-back traffic.
module tb_data_mem_bytelane;

  logic clk;
  logic reset;
  int   n_tot;
  int   n_bad;

  data_mem_bytelane_if #(.ADDR_WIDTH(32)) bus ();

  data_mem_bytelane #(
    .DEPTH_WORDS(512),
    .ADDR_WIDTH (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.chip_select = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_funct3  = '0;
    bus.req_wdata   = '0;
  endtask

  // Called at a negedge; returns at the negedge after the response
  task automatic xfer(input logic w,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd,
                      output logic er);
    bus.chip_select = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_funct3  = f3;
    bus.req_addr    = a;
    bus.req_wdata   = wd;
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_error;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.req_ready && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 511) begin
        chk("busy@511", {31'b0, bus.init_busy}, 32'd1);
      end
    end
  endtask

  task automatic ld(input string tag,
                    input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    xfer(1'b0, f3, a, 32'h0, rd, er);
    chk(tag, rd, exp);
    chk({tag, "_err"}, {31'b0, er}, 32'd0);
  endtask

  task automatic st(input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    xfer(1'b1, f3, a, wd, rd, er);
    chk("st_err", {31'b0, er}, 32'd0);
  endtask

  task automatic bad(input string tag,
                     input logic w,
                     input logic [2:0] f3,
                     input logic [31:0] a);
    logic [31:0] rd;
    logic        er;
    xfer(w, f3, a, 32'h1234_5678, rd, er);
    chk({tag, "_err"}, {31'b0, er}, 32'd1);
    chk({tag, "_data"}, rd, 32'h0);
  endtask

  logic [31:0] t6_dat [8];
  logic        t6_cs  [8];
  logic        t6_wr  [8];
  logic        t6_ev  [8];
  logic [31:0] t6_ed  [8];

  initial begin
    int cnt;
    int pulses;
    n_tot = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_bus();

    // 1: reset values and clear sweep length
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_busy", {31'b0, bus.init_busy}, 32'd1);
    chk("rst_rvalid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rerr", {31'b0, bus.rsp_error}, 32'd0);
    reset = 1'b0;
    wait_ready(cnt);
    chk("sweep_len", cnt, 32'd512);
    chk("busy_done", {31'b0, bus.init_busy}, 32'd0);
    ld("lw_1fc", 3'b010, 32'h1FC, 32'h0);

    // 2: load extension
    st(3'b010, 32'h10, 32'h80FF7F01);
    ld("lb_10", 3'b000, 32'h10, 32'h00000001);
    ld("lb_11", 3'b000, 32'h11, 32'h0000007F);
    ld("lb_13", 3'b000, 32'h13, 32'hFFFFFF80);
    ld("lbu_13", 3'b100, 32'h13, 32'h00000080);
    ld("lh_12", 3'b001, 32'h12, 32'hFFFF80FF);
    ld("lhu_12", 3'b101, 32'h12, 32'h000080FF);
    ld("lh_10", 3'b001, 32'h10, 32'h00007F01);

    // 3: partial stores keep other lanes
    st(3'b010, 32'h20, 32'h11223344);
    st(3'b000, 32'h21, 32'h000000AA);
    ld("lw_sb", 3'b010, 32'h20, 32'h1122AA44);
    st(3'b001, 32'h22, 32'h0000BEEF);
    ld("lw_sh", 3'b010, 32'h20, 32'hBEEFAA44);
    @(negedge clk);
    chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("hold_rdata", bus.rsp_rdata, 32'hBEEFAA44);

    // 4: faults leave memory untouched
    bad("sh_21", 1'b1, 3'b001, 32'h21);
    bad("lw_22", 1'b0, 3'b010, 32'h22);
    bad("ld_f011", 1'b0, 3'b011, 32'h20);
    bad("sb_f100", 1'b1, 3'b100, 32'h20);
    bad("sw_800", 1'b1, 3'b010, 32'h800);
    ld("lw_20_kept", 3'b010, 32'h20, 32'hBEEFAA44);
    ld("lw_0_kept", 3'b010, 32'h0, 32'h0);
    st(3'b010, 32'h7FC, 32'hCAFEF00D);
    ld("lw_7fc", 3'b010, 32'h7FC, 32'hCAFEF00D);

    // 5: reset mid-sweep restarts and memory is cleared
    st(3'b010, 32'h1FC, 32'hDEADBEEF);
    st(3'b010, 32'h0, 32'hDEADBEEF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    bus.chip_select = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_funct3  = 3'b010;
    bus.req_addr    = 32'h1FC;
    repeat (100) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    chk("mid_ready", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_bus();
    wait_ready(cnt);
    chk("resweep_len", cnt, 32'd512);
    chk("sweep_rsp", pulses, 32'd0);
    ld("clr_1fc", 3'b010, 32'h1FC, 32'h0);
    ld("clr_0", 3'b010, 32'h0, 32'h0);

    // 6: back-to-back traffic with one deselected cycle
    t6_dat = '{32'hA5A50001, 32'h0, 32'h5A5A0002, 32'h0,
               32'hC3C30004, 32'h0, 32'h3C3C0006, 32'h0};
    t6_cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t6_wr  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t6_ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t6_ed  = '{32'h0, 32'hA5A50001, 32'h0, 32'h5A5A0002,
               32'h0, 32'h5A5A0002, 32'h0, 32'h3C3C0006};
    pulses = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        if (bus.rsp_valid) pulses++;
        chk($sformatf("b2b_v%0d", k - 1),
            {31'b0, bus.rsp_valid}, {31'b0, t6_ev[k-1]});
        if (t6_ev[k-1]) begin
          chk($sformatf("b2b_d%0d", k - 1),
              bus.rsp_rdata, t6_ed[k-1]);
        end
      end
      if (k < 8) begin
        bus.chip_select = t6_cs[k];
        bus.req_valid   = 1'b1;
        bus.req_write   = t6_wr[k];
        bus.req_funct3  = 3'b010;
        bus.req_addr    = 32'h40;
        bus.req_wdata   = t6_dat[k];
        @(negedge clk);
      end else begin
        idle_bus();
      end
    end
    chk("b2b_pulses", pulses, 32'd7);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
